// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle between the UART receive FIFO and the IO register window.
// The IO decode drives the pop and error-clear strobes; the receiver returns
// the show-ahead head byte, occupancy and the two sticky error flags.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rdEn_i;
  logic          clrErr_i;
  logic [7:0]    rdData_o;
  logic          rdValid_o;
  logic [CW-1:0] count_o;
  logic          frameErr_o;
  logic          overrun_o;

  // IO register window side
  modport master (
    output rdEn_i, clrErr_i,
    input  rdData_o, rdValid_o, count_o, frameErr_o, overrun_o
  );

  // Receiver side
  modport slave (
    input  rdEn_i, clrErr_i,
    output rdData_o, rdValid_o, count_o, frameErr_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a show-ahead receive FIFO and sticky framing /
// overrun flags. The raw line is double-flopped, framed by a small FSM with a
// single shared bit-period counter, and completed bytes are queued on the edge
// that ends the stop-bit sample cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rxd_i,
  uart_rx_fifo_if.slave   bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  localparam logic [BCW-1:0] BC_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BC_ZERO = BCW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser
  logic sync1_q;
  logic rxs_q;

  // Receive FSM
  state_t         state_q;
  logic [BCW-1:0] bc_q;
  logic [2:0]     bitIdx_q;
  logic [7:0]     shift_q;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          frameErr_q, frameErr_d;
  logic          overrun_q, overrun_d;

  logic stop_sample_s;
  logic push_s;
  logic ferr_set_s;
  logic full_s;
  logic empty_s;
  logic pop_s;
  logic wr_s;
  logic ovr_set_s;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
    end
  end

  // Frame FSM: start-bit qualification, mid-bit data sampling, stop check,
  // and a BREAK state so a held-low line yields a single framing error.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      bc_q     <= BC_ZERO;
      bitIdx_q <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            bc_q    <= BC_HALF;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bc_q == BC_ZERO) begin
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              bc_q     <= BC_FULL;
              bitIdx_q <= 3'd0;
              state_q  <= S_DATA;
            end
          end else begin
            bc_q <= bc_q - BCW'(1);
          end
        end
        S_DATA: begin
          if (bc_q == BC_ZERO) begin
            shift_q  <= {rxs_q, shift_q[7:1]};
            bc_q     <= BC_FULL;
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            bc_q <= bc_q - BCW'(1);
          end
        end
        S_STOP: begin
          if (bc_q == BC_ZERO) begin
            state_q <= rxs_q ? S_IDLE : S_BREAK;
          end else begin
            bc_q <= bc_q - BCW'(1);
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stop-bit sample decode drives the push / framing-error strobes directly so
  // the byte lands on the same edge that ends the stop sample cycle.
  assign stop_sample_s = (state_q == S_STOP) && (bc_q == BC_ZERO);
  assign push_s        = stop_sample_s && rxs_q;
  assign ferr_set_s    = stop_sample_s && !rxs_q;

  assign full_s    = (count_q == CW'(FIFO_DEPTH));
  assign empty_s   = (count_q == CW'(0));
  assign pop_s     = bus.rdEn_i && !empty_s;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign wr_s      = push_s && (!full_s || pop_s);
  assign ovr_set_s = push_s && full_s && !pop_s;

  // FIFO pointer, occupancy and sticky-flag next state; a new error beats clear.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    if (wr_s) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end else begin
      wrPtr_d = wrPtr_q;
    end
    if (pop_s) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end else begin
      rdPtr_d = rdPtr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d    = (count_d != CW'(0));
    frameErr_d = ferr_set_s || (frameErr_q && !bus.clrErr_i);
    overrun_d  = ovr_set_s  || (overrun_q  && !bus.clrErr_i);
  end

  // FIFO control and status registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wrPtr_q    <= {AW{1'b0}};
      rdPtr_q    <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  // FIFO storage; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_q[wrPtr_q] <= shift_q;
    end
  end

  assign bus.rdData_o   = mem_q[rdPtr_q];
  assign bus.rdValid_o  = valid_q;
  assign bus.count_o    = count_q;
  assign bus.frameErr_o = frameErr_q;
  assign bus.overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT = 16, FIFO_DEPTH = 4):
// a table of scenario steps with hand-derived expectations, hand-written
// corner sequences, and a randomized phase checked against a queue model.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  localparam int OP_FRAME  = 0;
  localparam int OP_POP    = 1;
  localparam int OP_CLR    = 2;
  localparam int OP_HOLD   = 3;
  localparam int OP_GLITCH = 4;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic       stop_v;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rxd;

  int checks;
  int errors;

  vec_t vq[$];

  logic [7:0] mq[$];
  logic       m_ferr;
  logic       m_ovr;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .rxd_i  (rxd),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one 8N1 frame; optionally pops during the push cycle or checks the
  // rdValid latency around the stop-bit sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit pop_at_push, input bit chk_lat);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (pop_at_push && i == 9) bus.rdEn_i = (c == 10);
        if (chk_lat && i == 9 && c == 10) chk("lat_before", int'(bus.rdValid_o), 0);
        @(posedge clk);
        #1;
        if (chk_lat && i == 9 && c == 10) chk("lat_after", int'(bus.rdValid_o), 1);
      end
    end
  endtask

  task automatic pulse_pop();
    bus.rdEn_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rdEn_i = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clrErr_i = 1'b1;
    @(posedge clk);
    #1;
    bus.clrErr_i = 1'b0;
  endtask

  task automatic add(input int op, input logic [7:0] d, input logic s, input int cnt,
                     input logic [7:0] head, input logic fe, input logic ov);
    vec_t v;
    v.op = op; v.data = d; v.stop_v = s; v.exp_count = cnt;
    v.exp_head = head; v.exp_ferr = fe; v.exp_ovr = ov;
    vq.push_back(v);
  endtask

  task automatic check_exp(input string tag, input int cnt, input logic [7:0] head,
                           input logic fe, input logic ov);
    chk({tag, "_count"}, int'(bus.count_o), cnt);
    chk({tag, "_valid"}, int'(bus.rdValid_o), (cnt != 0) ? 1 : 0);
    if (cnt != 0) chk({tag, "_head"}, int'(bus.rdData_o), int'(head));
    chk({tag, "_ferr"}, int'(bus.frameErr_o), int'(fe));
    chk({tag, "_ovr"}, int'(bus.overrun_o), int'(ov));
  endtask

  task automatic check_model(input string tag);
    check_exp(tag, mq.size(), (mq.size() != 0) ? mq[0] : 8'h00, m_ferr, m_ovr);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rxd = 1'b1;
    bus.rdEn_i = 1'b0;
    bus.clrErr_i = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    check_exp("reset", 0, 8'h00, 1'b0, 1'b0);

    // Scenario table: {op, data, stop, expected count, head, ferr, ovr}
    add(OP_FRAME, 8'hA5, 1'b1, 1, 8'hA5, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h01, 1'b1, 1, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h02, 1'b1, 2, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h03, 1'b1, 3, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h04, 1'b1, 4, 8'h01, 1'b0, 1'b0);
    add(OP_FRAME, 8'h05, 1'b1, 4, 8'h01, 1'b0, 1'b1);
    add(OP_FRAME, 8'h06, 1'b1, 4, 8'h01, 1'b0, 1'b1);
    add(OP_POP,   8'h00, 1'b1, 3, 8'h02, 1'b0, 1'b1);
    add(OP_POP,   8'h00, 1'b1, 2, 8'h03, 1'b0, 1'b1);
    add(OP_POP,   8'h00, 1'b1, 1, 8'h04, 1'b0, 1'b1);
    add(OP_POP,   8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1);
    add(OP_CLR,   8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h3C, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    add(OP_HOLD,  8'h00, 1'b1, 0, 8'h00, 1'b1, 1'b0);
    add(OP_FRAME, 8'h55, 1'b1, 1, 8'h55, 1'b1, 1'b0);
    add(OP_CLR,   8'h00, 1'b1, 1, 8'h55, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    add(OP_GLITCH,8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    add(OP_FRAME, 8'h96, 1'b1, 1, 8'h96, 1'b0, 1'b0);
    add(OP_POP,   8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      case (vq[i].op)
        OP_FRAME: send_frame(vq[i].data, vq[i].stop_v, 1'b0, i == 0);
        OP_POP:   pulse_pop();
        OP_CLR:   pulse_clr();
        OP_HOLD: begin
          rxd = 1'b0;
          idle(40 * CPB);
          rxd = 1'b1;
          idle(2 * CPB);
        end
        OP_GLITCH: begin
          rxd = 1'b0;
          idle(3);
          rxd = 1'b1;
          idle(2 * CPB);
        end
        default: ;
      endcase
      check_exp($sformatf("vec%0d", i), vq[i].exp_count, vq[i].exp_head,
                vq[i].exp_ferr, vq[i].exp_ovr);
    end

    // Full FIFO with a pop landing in the exact push cycle of the 5th byte.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0);
    check_exp("full", 4, 8'h11, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check_exp("pushpop", 4, 8'h22, 1'b0, 1'b0);
    pulse_pop();
    check_exp("pp_pop1", 3, 8'h33, 1'b0, 1'b0);
    pulse_pop();
    check_exp("pp_pop2", 2, 8'h44, 1'b0, 1'b0);
    pulse_pop();
    check_exp("pp_pop3", 1, 8'h5A, 1'b0, 1'b0);
    pulse_pop();
    check_exp("pp_pop4", 0, 8'h00, 1'b0, 1'b0);
    pulse_pop();
    check_exp("pop_empty", 0, 8'h00, 1'b0, 1'b0);

    // Randomized phase against the queue model.
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r <= 4) begin
        send_frame(b, 1'b1, 1'b0, 1'b0);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
      end else if (r == 5) begin
        send_frame(b, 1'b0, 1'b0, 1'b0);
        m_ferr = 1'b1;
        rxd = 1'b1;
        idle(CPB);
      end else if (r <= 7) begin
        pulse_pop();
        if (mq.size() != 0) void'(mq.pop_front());
      end else if (r == 8) begin
        pulse_clr();
        m_ferr = 1'b0;
        m_ovr = 1'b0;
      end else begin
        idle(int'($urandom_range(1, 40)));
      end
      check_model($sformatf("rnd%0d", n));
    end

    // Reset asserted in the middle of the data bits abandons the frame.
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(CPB);
    rxd = 1'b0;
    idle(CPB);
    rst_n = 1'b0;
    rxd = 1'b1;
    idle(3);
    check_exp("in_reset", 0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2 * CPB);
    check_exp("post_reset", 0, 8'h00, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    idle(CPB);
    check_exp("after_7e", 1, 8'h7E, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
